// File: rtl/z80_io_master.sv
// Z80-style bus master: turns single host requests into Z80 memory or I/O
// read/write bus cycles (T1, T2, optional TW, T3) on a divided bus clock.
// Optional feature macro: WAIT_TIMEOUT_EN. When it is defined, a WAIT line
// held low for 255 consecutive wait states ends the cycle with rsp_err = 1.
// When it is undefined, wait states repeat for as long as WAIT stays low.
module z80_io_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk25,
    input  logic       RESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_mem,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       Z80_CLK,
    output logic [7:0] A,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    input  logic [7:0] D_IN,
    output logic       MREQ,
    output logic       IORQ,
    output logic       RD,
    output logic       WR,
    output logic       M1,
    input  logic       WAIT
);

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4
    } state_t;

    // Bus clock divider
    logic [7:0] div_q;
    logic [7:0] div_d;
    logic       zclk_q;
    logic       zclk_d;
    logic       tick_s;

    // Bus cycle state and latched request
    state_t     state_q;
    logic       pend_q;
    logic       cmd_ready_q;
    logic       lat_write_q;
    logic       lat_mem_q;
    logic [7:0] lat_addr_q;
    logic [7:0] lat_data_q;

    // Registered bus and response outputs
    logic [7:0] a_q;
    logic [7:0] dout_q;
    logic       doe_q;
    logic       mreq_q;
    logic       iorq_q;
    logic       rd_q;
    logic       wr_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;

    // Wait-state decision on the current tick
    logic       wait_hold_s;
    logic       timeout_s;

`ifdef WAIT_TIMEOUT_EN
    logic [7:0] wcnt_q;
    logic       tout_q;
    logic       rsp_err_q;
`endif

    // Divider next state: toggle Z80_CLK every CLK_DIV cycles, tick on each rise
    always_comb begin
        div_d  = div_q + 8'd1;
        zclk_d = zclk_q;
        tick_s = 1'b0;
        if (div_q == DIV_MAX) begin
            div_d  = 8'd0;
            zclk_d = ~zclk_q;
            tick_s = ~zclk_q;
        end else begin
            div_d  = div_q + 8'd1;
        end
    end

    // Divider registers
    always_ff @(posedge clk25 or negedge RESET) begin
        if (!RESET) begin
            div_q  <= 8'd0;
            zclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            zclk_q <= zclk_d;
        end
    end

    // Decide whether a low WAIT holds the cycle in TW or (on timeout) releases it
    always_comb begin
`ifdef WAIT_TIMEOUT_EN
        wait_hold_s = ~WAIT & (wcnt_q != 8'hFF);
        timeout_s   = ~WAIT & (wcnt_q == 8'hFF);
`else
        wait_hold_s = ~WAIT;
        timeout_s   = 1'b0;
`endif
    end

    // Bus cycle sequencer with registered strobes, address, data and response
    always_ff @(posedge clk25 or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            lat_write_q <= 1'b0;
            lat_mem_q   <= 1'b0;
            lat_addr_q  <= 8'h00;
            lat_data_q  <= 8'h00;
            a_q         <= 8'h00;
            dout_q      <= 8'h00;
            doe_q       <= 1'b0;
            mreq_q      <= 1'b1;
            iorq_q      <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
`ifdef WAIT_TIMEOUT_EN
            wcnt_q      <= 8'd0;
            tout_q      <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        // Request latched: start T1 on the next bus clock rise
                        if (tick_s) begin
                            state_q <= ST_T1;
                            pend_q  <= 1'b0;
                            a_q     <= lat_addr_q;
                            dout_q  <= lat_write_q ? lat_data_q : 8'h00;
                            doe_q   <= lat_write_q;
                            mreq_q  <= ~lat_mem_q;
`ifdef WAIT_TIMEOUT_EN
                            wcnt_q  <= 8'd0;
                            tout_q  <= 1'b0;
`endif
                        end
                    end else if (cmd_valid && cmd_ready_q) begin
                        pend_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        lat_write_q <= cmd_write;
                        lat_mem_q   <= cmd_mem;
                        lat_addr_q  <= cmd_addr;
                        lat_data_q  <= cmd_data;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_T1: begin
                    if (tick_s) begin
                        state_q <= ST_T2;
                        mreq_q  <= ~lat_mem_q;
                        iorq_q  <= lat_mem_q;
                        rd_q    <= lat_write_q;
                        wr_q    <= ~lat_write_q;
                    end
                end
                ST_T2: begin
                    if (tick_s) begin
                        if (!lat_mem_q) begin
                            // I/O cycles always get one automatic wait state
                            state_q <= ST_TW;
                        end else if (wait_hold_s) begin
                            state_q <= ST_TW;
`ifdef WAIT_TIMEOUT_EN
                            wcnt_q  <= wcnt_q + 8'd1;
`endif
                        end else begin
                            state_q    <= ST_T3;
                            rsp_data_q <= (timeout_s || lat_write_q) ? 8'h00 : D_IN;
`ifdef WAIT_TIMEOUT_EN
                            tout_q     <= timeout_s;
`endif
                        end
                    end
                end
                ST_TW: begin
                    if (tick_s) begin
                        if (wait_hold_s) begin
                            state_q <= ST_TW;
`ifdef WAIT_TIMEOUT_EN
                            wcnt_q  <= wcnt_q + 8'd1;
`endif
                        end else begin
                            state_q    <= ST_T3;
                            rsp_data_q <= (timeout_s || lat_write_q) ? 8'h00 : D_IN;
`ifdef WAIT_TIMEOUT_EN
                            tout_q     <= timeout_s;
`endif
                        end
                    end
                end
                ST_T3: begin
                    if (tick_s) begin
                        state_q     <= ST_IDLE;
                        mreq_q      <= 1'b1;
                        iorq_q      <= 1'b1;
                        rd_q        <= 1'b1;
                        wr_q        <= 1'b1;
                        doe_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
`ifdef WAIT_TIMEOUT_EN
                        rsp_err_q   <= tout_q;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    mreq_q  <= 1'b1;
                    iorq_q  <= 1'b1;
                    rd_q    <= 1'b1;
                    wr_q    <= 1'b1;
                    doe_q   <= 1'b0;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
`ifdef WAIT_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif
    assign Z80_CLK   = zclk_q;
    assign A         = a_q;
    assign D_OUT     = dout_q;
    assign D_OE      = doe_q;
    assign MREQ      = mreq_q;
    assign IORQ      = iorq_q;
    assign RD        = rd_q;
    assign WR        = wr_q;
    // No opcode fetches are ever issued
    assign M1        = 1'b1;

endmodule

// File: tb/tb_z80_io_master.sv
// Self-checking bench for z80_io_master. Expected bus behaviour comes from a
// T-state arithmetic model: a cycle of N T-states starts at the first bus
// clock rise after acceptance and each T-state is 2*CLK_DIV clk25 cycles.
module tb_z80_io_master;

    localparam int D       = 4;
    localparam int D2      = 2 * D;
    localparam int TOUT_TW = 255;

    logic       clk25 = 1'b0;
    logic       RESET = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic       cmd_mem = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] D_IN = 8'h00;
    logic       WAIT = 1'b1;

    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       Z80_CLK;
    logic [7:0] A;
    logic [7:0] D_OUT;
    logic       D_OE;
    logic       MREQ;
    logic       IORQ;
    logic       RD;
    logic       WR;
    logic       M1;

    z80_io_master #(.CLK_DIV(D)) dut (
        .clk25(clk25), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_mem(cmd_mem), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .Z80_CLK(Z80_CLK), .A(A), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
        .MREQ(MREQ), .IORQ(IORQ), .RD(RD), .WR(WR), .M1(M1), .WAIT(WAIT)
    );

    always #5 clk25 = ~clk25;

    // clk25 edges since reset release
    int ecount = 0;
    always @(posedge clk25 or negedge RESET) begin
        if (!RESET) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          k;
        logic [24:0] v;
    } samp_t;
    samp_t trace[$];

    int         acc_k;
    int         rsp_k;
    logic [7:0] rsp_d;
    logic       rsp_e;

    function automatic logic [24:0] obs();
        return {D_OUT, A, MREQ, IORQ, RD, WR, M1, D_OE, cmd_ready, rsp_valid, Z80_CLK};
    endfunction

    function automatic logic [33:0] reset_view();
        return {Z80_CLK, A, D_OUT, D_OE, MREQ, IORQ, RD, WR, M1, rsp_valid, rsp_data, rsp_err, cmd_ready};
    endfunction

    function automatic int next_tick(int e);
        int t = e + 1;
        while ((t % D2) != D) t++;
        return t;
    endfunction

    // T-states of a cycle: 3 (mem) or 4 (I/O) plus one per low WAIT sample
    function automatic int tstates(logic m, int lo);
        int base = m ? 3 : 4;
        if (lo >= 0) return base + lo;
`ifdef WAIT_TIMEOUT_EN
        return base + TOUT_TW;
`else
        return 1000000;
`endif
    endfunction

    function automatic logic [24:0] model_bus(int k, int t1, int n, logic w, logic m,
                                              logic [7:0] addr, logic [7:0] data);
        int   rsp = t1 + n * D2;
        logic act = (k >= t1) && (k < rsp);
        logic t2p = act && (k >= t1 + D2);
        logic [8:0] ctl;
        ctl = {~(m & act), ~(~m & t2p), ~(~w & t2p), ~(w & t2p), 1'b1,
               w & act, (k >= rsp) ? 1'b1 : 1'b0, (k == rsp) ? 1'b1 : 1'b0,
               ((k / D) % 2) == 1 ? 1'b1 : 1'b0};
        return {(act && w) ? data : 8'h00, act ? addr : 8'h00, ctl};
    endfunction

    function automatic logic [24:0] model_mask(int k, int t1, int n, logic w);
        logic act = (k >= t1) && (k < t1 + n * D2);
        return {(act && w) ? 8'hFF : 8'h00, act ? 8'hFF : 8'h00, 9'h1FF};
    endfunction

    // Index of the first trace sample that disagrees with the model, or -1
    function automatic int first_bad(int t1, int n, logic w, logic m,
                                     logic [7:0] addr, logic [7:0] data);
        foreach (trace[i]) begin
            logic [24:0] mk;
            mk = model_mask(trace[i].k, t1, n, w);
            if ((trace[i].v & mk) !== (model_bus(trace[i].k, t1, n, w, m, addr, data) & mk))
                return i;
        end
        return -1;
    endfunction

    // Issue one request, drive WAIT low for lo samples (-1 = forever), record the bus
    task automatic run_cmd(input logic w, input logic m, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] din, input int lo,
                           input int max_edges, input logic hold, input logic nw,
                           input logic nm, input logic [7:0] na, input logic [7:0] nd);
        int t1;
        int last_low;
        bit ok;
        trace.delete();
        acc_k = -1; rsp_k = -1; rsp_d = 8'h00; rsp_e = 1'b0;
        @(negedge clk25);
        cmd_write = w; cmd_mem = m; cmd_addr = addr; cmd_data = data;
        cmd_valid = 1'b1; D_IN = din; WAIT = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready === 1'b1) begin ok = 1; break; end
            @(negedge clk25);
        end
        if (!ok) begin
            checks++;
            $display("FAIL accept: cmd_ready stayed %b for 200 cycles, want 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk25); #1;
        acc_k = ecount;
        trace.push_back('{acc_k, obs()});
        t1 = next_tick(acc_k);
        if (lo < 0)       last_low = 32'h7FFFFFFF;
        else if (lo == 0) last_low = -1;
        else              last_low = t1 + ((m ? 2 : 3) + lo - 1) * D2;
        for (int j = 0; j < max_edges; j++) begin
            @(negedge clk25);
            if (j == 0) begin
                if (hold) begin
                    cmd_write = nw; cmd_mem = nm; cmd_addr = na; cmd_data = nd;
                end else begin
                    cmd_valid = 1'b0;
                    cmd_write = 1'($urandom); cmd_mem = 1'($urandom);
                    cmd_addr = 8'($urandom); cmd_data = 8'($urandom);
                end
            end
            WAIT = ((ecount + 1) <= last_low) ? 1'b0 : 1'b1;
            @(posedge clk25); #1;
            trace.push_back('{ecount, obs()});
            if (rsp_valid === 1'b1) begin
                rsp_k = ecount; rsp_d = rsp_data; rsp_e = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [33:0] want;
        want = {1'b0, 8'h00, 8'h00, 1'b0, 5'b11111, 1'b0, 8'h00, 1'b0, 1'b0};
        RESET = 1'b0;
        repeat (3) @(negedge clk25);
        checks++;
        if (reset_view() !== want) $display("FAIL reset_state got %h want %h", reset_view(), want);
        else passes++;
        RESET = 1'b1;
        @(posedge clk25); #1;
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", cmd_ready);
        else passes++;
        repeat (D - 2) @(posedge clk25);
        #1;
        checks++;
        if (Z80_CLK !== 1'b0) $display("FAIL zclk_low_phase got %b want 0", Z80_CLK);
        else passes++;
        @(posedge clk25); #1;
        checks++;
        if (Z80_CLK !== 1'b1) $display("FAIL zclk_first_rise got %b want 1", Z80_CLK);
        else passes++;
    endtask

    task automatic test_io_write();
        int t1, bi;
        run_cmd(1'b1, 1'b0, 8'h42, 8'hA5, 8'h00, 0, 200, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        t1 = next_tick(acc_k);
        bi = first_bad(t1, 4, 1'b1, 1'b0, 8'h42, 8'hA5);
        checks++;
        if (bi !== -1) $display("FAIL io_write_bus k=%0d got %h want %h", trace[bi].k, trace[bi].v,
                                model_bus(trace[bi].k, t1, 4, 1'b1, 1'b0, 8'h42, 8'hA5));
        else passes++;
        checks++;
        if (rsp_k !== t1 + 32) $display("FAIL io_write_len got %0d want %0d", rsp_k, t1 + 32);
        else passes++;
        checks++;
        if (rsp_e !== 1'b0) $display("FAIL io_write_err got %b want 0", rsp_e);
        else passes++;
    endtask

    task automatic test_mem_read();
        int t1, bi;
        run_cmd(1'b0, 1'b1, 8'h10, 8'h00, 8'h3C, 0, 200, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        t1 = next_tick(acc_k);
        bi = first_bad(t1, 3, 1'b0, 1'b1, 8'h10, 8'h00);
        checks++;
        if (bi !== -1) $display("FAIL mem_read_bus k=%0d got %h want %h", trace[bi].k, trace[bi].v,
                                model_bus(trace[bi].k, t1, 3, 1'b0, 1'b1, 8'h10, 8'h00));
        else passes++;
        checks++;
        if (rsp_k !== t1 + 24) $display("FAIL mem_read_len got %0d want %0d", rsp_k, t1 + 24);
        else passes++;
        checks++;
        if (rsp_d !== 8'h3C) $display("FAIL mem_read_data got %h want 3c", rsp_d);
        else passes++;
    endtask

    task automatic test_io_read_wait();
        int t1, bi;
        run_cmd(1'b0, 1'b0, 8'h77, 8'h00, 8'h5A, 3, 200, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        t1 = next_tick(acc_k);
        bi = first_bad(t1, 7, 1'b0, 1'b0, 8'h77, 8'h00);
        checks++;
        if (bi !== -1) $display("FAIL io_wait_bus k=%0d got %h want %h", trace[bi].k, trace[bi].v,
                                model_bus(trace[bi].k, t1, 7, 1'b0, 1'b0, 8'h77, 8'h00));
        else passes++;
        checks++;
        if (rsp_k !== t1 + 7 * D2) $display("FAIL io_wait_len got %0d want %0d", rsp_k, t1 + 7 * D2);
        else passes++;
        checks++;
        if (rsp_d !== 8'h5A) $display("FAIL io_wait_data got %h want 5a", rsp_d);
        else passes++;
    endtask

    task automatic test_random();
        logic w, m;
        logic [7:0] ad, da, di;
        int lo, n, t1, bi;
        for (int it = 0; it < 16; it++) begin
            w = 1'($urandom); m = 1'($urandom);
            ad = 8'($urandom); da = 8'($urandom); di = 8'($urandom);
            lo = int'($urandom_range(0, 3));
            n = tstates(m, lo);
            run_cmd(w, m, ad, da, di, lo, 200, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            t1 = next_tick(acc_k);
            bi = first_bad(t1, n, w, m, ad, da);
            checks++;
            if (bi !== -1) $display("FAIL rand_bus it=%0d k=%0d got %h want %h", it, trace[bi].k,
                                    trace[bi].v, model_bus(trace[bi].k, t1, n, w, m, ad, da));
            else passes++;
            checks++;
            if (rsp_k !== t1 + n * D2) $display("FAIL rand_len it=%0d got %0d want %0d", it, rsp_k, t1 + n * D2);
            else passes++;
            if (!w) begin
                checks++;
                if (rsp_d !== di) $display("FAIL rand_data it=%0d got %h want %h", it, rsp_d, di);
                else passes++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int r1, t1, bi;
        logic [24:0] v_acc, v_t1;
        run_cmd(1'b1, 1'b1, 8'h21, 8'h5C, 8'h00, 0, 200, 1'b1, 1'b1, 1'b0, 8'h84, 8'h96);
        r1 = rsp_k;
        t1 = next_tick(acc_k);
        checks++;
        if (r1 !== t1 + 24) $display("FAIL b2b_first_len got %0d want %0d", r1, t1 + 24);
        else passes++;
        run_cmd(1'b1, 1'b0, 8'h84, 8'h96, 8'h00, 0, 200, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (acc_k !== r1 + 1) $display("FAIL b2b_accept got %0d want %0d", acc_k, r1 + 1);
        else passes++;
        v_acc = 25'h0; v_t1 = 25'h0;
        foreach (trace[i]) begin
            if (trace[i].k == r1 + 1)  v_acc = trace[i].v;
            if (trace[i].k == r1 + D2) v_t1  = trace[i].v;
        end
        checks++;
        if (v_acc[8:3] !== 6'b111110) $display("FAIL b2b_gap_strobes got %b want 111110", v_acc[8:3]);
        else passes++;
        checks++;
        if (v_t1[16:9] !== 8'h84 || v_t1[3] !== 1'b1)
            $display("FAIL b2b_second_t1 got A=%h oe=%b want A=84 oe=1", v_t1[16:9], v_t1[3]);
        else passes++;
        t1 = next_tick(acc_k);
        bi = first_bad(t1, 4, 1'b1, 1'b0, 8'h84, 8'h96);
        checks++;
        if (bi !== -1) $display("FAIL b2b_second_bus k=%0d got %h want %h", trace[bi].k, trace[bi].v,
                                model_bus(trace[bi].k, t1, 4, 1'b1, 1'b0, 8'h84, 8'h96));
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [33:0] want;
        bit seen;
        int t1, bi;
        want = {1'b0, 8'h00, 8'h00, 1'b0, 5'b11111, 1'b0, 8'h00, 1'b0, 1'b0};
        run_cmd(1'b0, 1'b0, 8'hE7, 8'h00, 8'h11, 10, 40, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (rsp_k !== -1 || IORQ !== 1'b0)
            $display("FAIL mid_in_tw got rsp_k=%0d IORQ=%b want -1 and 0", rsp_k, IORQ);
        else passes++;
        @(negedge clk25); #2;
        RESET = 1'b0;
        #1;
        checks++;
        if (reset_view() !== want) $display("FAIL mid_async_reset got %h want %h", reset_view(), want);
        else passes++;
        seen = 0;
        repeat (10) begin
            @(posedge clk25); #1;
            if (rsp_valid !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) $display("FAIL mid_no_rsp got rsp_valid=1 want 0");
        else passes++;
        @(negedge clk25);
        RESET = 1'b1; WAIT = 1'b1;
        @(posedge clk25); #1;
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL mid_release_ready got %b want 1", cmd_ready);
        else passes++;
        run_cmd(1'b1, 1'b1, 8'h3E, 8'hC9, 8'h00, 1, 200, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        t1 = next_tick(acc_k);
        bi = first_bad(t1, 4, 1'b1, 1'b1, 8'h3E, 8'hC9);
        checks++;
        if (bi !== -1 || rsp_k !== t1 + 4 * D2)
            $display("FAIL mid_recover got rsp_k=%0d bad_idx=%0d want %0d and -1", rsp_k, bi, t1 + 4 * D2);
        else passes++;
    endtask

    task automatic test_wait_stuck();
        int t1, n, bi;
`ifdef WAIT_TIMEOUT_EN
        n = tstates(1'b1, -1);
        run_cmd(1'b0, 1'b1, 8'h55, 8'h00, 8'hC3, -1, 270 * D2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        t1 = next_tick(acc_k);
        checks++;
        if (rsp_k !== t1 + n * D2) $display("FAIL timeout_len got %0d want %0d", rsp_k, t1 + n * D2);
        else passes++;
        checks++;
        if (rsp_e !== 1'b1 || rsp_d !== 8'h00)
            $display("FAIL timeout_resp got err=%b data=%h want 1 and 00", rsp_e, rsp_d);
        else passes++;
        bi = first_bad(t1, n, 1'b0, 1'b1, 8'h55, 8'h00);
        checks++;
        if (bi !== -1) $display("FAIL timeout_bus k=%0d got %h", trace[bi].k, trace[bi].v);
        else passes++;
`else
        n = tstates(1'b0, -1);
        run_cmd(1'b0, 1'b0, 8'h55, 8'h00, 8'hC3, -1, 1000 * D2 + D2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        t1 = next_tick(acc_k);
        checks++;
        if (rsp_k !== -1) $display("FAIL stuck_no_rsp got rsp at %0d want none", rsp_k);
        else passes++;
        checks++;
        if (IORQ !== 1'b0 || RD !== 1'b0 || rsp_err !== 1'b0)
            $display("FAIL stuck_strobes got IORQ=%b RD=%b err=%b want 0 0 0", IORQ, RD, rsp_err);
        else passes++;
        bi = first_bad(t1, n, 1'b0, 1'b0, 8'h55, 8'h00);
        checks++;
        if (bi !== -1) $display("FAIL stuck_bus k=%0d got %h", trace[bi].k, trace[bi].v);
        else passes++;
`endif
        @(negedge clk25);
        RESET = 1'b0; WAIT = 1'b1;
        @(negedge clk25);
        RESET = 1'b1;
    endtask

    initial begin
        test_reset();
        test_io_write();
        test_mem_read();
        test_io_read_wait();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_wait_stuck();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
